keyboard_receiver: RTL

KEYBOARD_RECEIVER -- requirements
Module: keyboard_receiver

---
 rtl/keyboard_receiver.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/keyboard_receiver.sv
// keyboard_receiver
//   PS/2 keyboard receiver with a scan-code FIFO and a 32-bit read port.
//   The raw PS/2 clock and data are synchronised. The clock is glitch-filtered,
//   and each filtered falling edge samples one frame bit. Complete frames go
//   into a FIFO. A bus read pops one byte and returns it together with the
//   sticky status flags and a free-running LFSR value.
//
// Parameters
//   FIFO_DEPTH     scan-code FIFO entries (power of two, 2..64)
//   FILTER_LEN     clocks ps2_clk must hold a new level before it is accepted
//   TIMEOUT_CYCLES idle clocks tolerated inside a frame before it is abandoned
//
// Ports
//   clock     system clock, rising edge
//   reset     asynchronous, active-high reset
//   ps2_clk   raw PS/2 clock (asynchronous)
//   ps2_data  raw PS/2 data (asynchronous)
//   read      bus read strobe; each rising edge with read high is one read
//   data_out  read word, high-impedance while read is low
//             [31:24] scan code (8'hFF when the FIFO is empty)
//             [17] parity_err, [16] overflow, [7:0] LFSR (0 when empty)
//
// Build option
//   KEYBOARD_PARITY_CHECK_EN : when defined, a frame whose eight data bits
//   plus its parity bit hold an even number of ones is dropped, and it sets
//   parity_err. When the macro is not defined, the parity bit is ignored and
//   parity_err reads 0.
module keyboard_receiver #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        read,
    output logic [31:0] data_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST    = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ------------------------------------------------------------------
    // Synchronisers and the clock glitch filter
    // ------------------------------------------------------------------
    logic          clk_meta_reg, clk_sync_reg, data_meta_reg, data_sync_reg;
    logic          clk_filt_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          clk_fall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_meta_reg  <= 1'b1;
            clk_sync_reg  <= 1'b1;
            data_meta_reg <= 1'b1;
            data_sync_reg <= 1'b1;
            clk_filt_reg  <= 1'b1;
            filt_cnt_reg  <= '0;
        end else begin
            clk_meta_reg  <= ps2_clk;
            clk_sync_reg  <= clk_meta_reg;
            data_meta_reg <= ps2_data;
            data_sync_reg <= data_meta_reg;
            // The new level is accepted only after it has differed from the
            // filtered level for FILTER_LEN consecutive clocks.
            if (clk_sync_reg != clk_filt_reg) begin
                if (filt_cnt_reg == FILT_LAST) begin
                    clk_filt_reg <= clk_sync_reg;
                    filt_cnt_reg <= '0;
                end else begin
                    filt_cnt_reg <= filt_cnt_reg + 1'b1;
                end
            end else begin
                filt_cnt_reg <= '0;
            end
        end
    end

    // This signal is high on the clock edge where the filtered level falls.
    assign clk_fall = clk_filt_reg & ~clk_sync_reg & (filt_cnt_reg == FILT_LAST);

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t        state_reg, state_next;
    logic [7:0]    shift_reg, shift_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [TW-1:0] timeout_reg, timeout_next;
    logic          push_req;
    logic          parity_err;
`ifdef KEYBOARD_PARITY_CHECK_EN
    logic          parity_bit_reg, parity_bit_next;
    logic          parity_set;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            timeout_reg <= '0;
`ifdef KEYBOARD_PARITY_CHECK_EN
            parity_bit_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            timeout_reg <= timeout_next;
`ifdef KEYBOARD_PARITY_CHECK_EN
            parity_bit_reg <= parity_bit_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        timeout_next = '0;
        push_req     = 1'b0;
`ifdef KEYBOARD_PARITY_CHECK_EN
        parity_bit_next = parity_bit_reg;
        parity_set      = 1'b0;
`endif
        // A frame that stalls in any state other than IDLE is abandoned.
        if (state_reg != IDLE && !clk_fall) begin
            if (timeout_reg == TIMEOUT_LAST) begin
                state_next = IDLE;
            end else begin
                timeout_next = timeout_reg + 1'b1;
            end
        end
        if (clk_fall) begin
            case (state_reg)
                IDLE: begin
                    if (!data_sync_reg) begin
                        state_next   = DATA;
                        bit_cnt_next = 3'd0;
                    end
                end
                DATA: begin
                    shift_next   = {data_sync_reg, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) state_next = PARITY;
                end
                PARITY: begin
`ifdef KEYBOARD_PARITY_CHECK_EN
                    parity_bit_next = data_sync_reg;
`endif
                    state_next = STOP;
                end
                default: begin
                    if (data_sync_reg) begin
`ifdef KEYBOARD_PARITY_CHECK_EN
                        if (^{shift_reg, parity_bit_reg}) push_req   = 1'b1;
                        else                              parity_set = 1'b1;
`else
                        push_req = 1'b1;
`endif
                    end
                    state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO, flags, LFSR and read register
    // ------------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic        fifo_empty, fifo_full, pop, push_ok, overflow_set;
    logic        overflow_reg;
    logic [7:0]  lfsr_reg;
    logic [31:0] data_reg;

    assign fifo_empty   = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                          (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop          = read & ~fifo_empty;
    // A full FIFO still accepts a push when the same edge pops.
    assign push_ok      = push_req & (~fifo_full | pop);
    assign overflow_set = push_req & fifo_full & ~pop;

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
    end

`ifdef KEYBOARD_PARITY_CHECK_EN
    logic parity_err_reg;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) parity_err_reg <= 1'b0;
        else       parity_err_reg <= (parity_err_reg & ~read) | parity_set;
    end
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
            lfsr_reg     <= 8'h01;
            data_reg     <= 32'hFF00_0000;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            // A read clears the flags it reports. A flag raised on the same
            // edge survives so that the next read reports it.
            overflow_reg <= (overflow_reg & ~read) | overflow_set;
            if (read) begin
                if (!fifo_empty)
                    data_reg <= {mem[rd_ptr_reg[AW-1:0]], 6'b0, parity_err, overflow_reg,
                                 8'h00, lfsr_reg};
                else
                    data_reg <= {8'hFF, 6'b0, parity_err, overflow_reg, 16'h0000};
            end
        end
    end

    assign data_out = read ? data_reg : 'z;
endmodule
